// File: rtl/fifo_row_reader.sv
// Row-oriented reader: pulls one row of words from an upstream threshold FIFO at a time,
// buffers them in a 2-entry skid and streams them downstream with a per-row last flag.
module fifo_row_reader #(
    parameter int unsigned WIDTH_OUT = 1152,
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_BITS:0]   row_words,
    input  logic [ADDR_BITS:0]   row_num,
    output logic [ADDR_BITS:0]   M_count,
    input  logic                 M_Ready,
    input  logic                 empty,
    input  logic [WIDTH_OUT-1:0] fifo_dout,
    output logic                 rd_en,
    output logic                 Next_Reg,
    output logic [WIDTH_OUT-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 done
);

    localparam int unsigned CW = ADDR_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_ROW = 3'd1,
        S_READ     = 3'd2,
        S_DRAIN    = 3'd3,
        S_FLUSH    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       words_q, words_d;
    logic [CW-1:0]       rows_q, rows_d;
    logic [CW-1:0]       row_cnt_q, row_cnt_d;
    logic [CW-1:0]       issued_q, issued_d;
    logic                done_q, done_d;
    logic                next_reg_q, next_reg_d;

    // Read issued last cycle: its data is on fifo_dout this cycle.
    logic                rd_pend_q, rd_pend_d;
    logic                rd_last_pend_q, rd_last_pend_d;

    // Skid buffer: head entry drives the outputs, spare holds the overflow word.
    logic [WIDTH_OUT-1:0] head_data_q, head_data_d;
    logic                 head_last_q, head_last_d;
    logic                 head_vld_q, head_vld_d;
    logic [WIDTH_OUT-1:0] spare_data_q, spare_data_d;
    logic                 spare_last_q, spare_last_d;
    logic                 spare_vld_q, spare_vld_d;

    logic                 pop_c;
    logic                 credit_ok_c;
    logic                 rd_en_c;
    logic                 rd_is_last_c;
    logic [1:0]           occ_c;

    assign pop_c = head_vld_q & out_ready;

    // Occupancy seen by a new read: buffered + in flight, net of this cycle's pop.
    always_comb begin
        occ_c       = 2'(head_vld_q) + 2'(spare_vld_q) + 2'(rd_pend_q) - 2'(pop_c);
        credit_ok_c = (occ_c < 2'd2);
    end

    assign rd_is_last_c = (CW'(issued_q + CW'(1)) == words_q);

    // Next-state and control for the row sequencer.
    always_comb begin
        state_d    = state_q;
        words_d    = words_q;
        rows_d     = rows_q;
        row_cnt_d  = row_cnt_q;
        issued_d   = issued_q;
        rd_en_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    words_d   = row_words;
                    rows_d    = row_num;
                    row_cnt_d = '0;
                    issued_d  = '0;
                    if ((row_words == '0) || (row_num == '0)) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_WAIT_ROW;
                    end
                end
            end
            S_WAIT_ROW: begin
                issued_d = '0;
                if (M_Ready) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                rd_en_c = rst_n && !empty && (issued_q < words_q) && credit_ok_c;
                if (rd_en_c) begin
                    issued_d = CW'(issued_q + CW'(1));
                    if (rd_is_last_c) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop_c && head_last_q) begin
                    row_cnt_d = CW'(row_cnt_q + CW'(1));
                    if (row_cnt_d == rows_q) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_WAIT_ROW;
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d         = (state_d == S_FLUSH);
        next_reg_d     = (state_d == S_FLUSH);
        rd_pend_d      = rd_en_c;
        rd_last_pend_d = rd_en_c && rd_is_last_c;
    end

    // Skid buffer push/pop; a simultaneous push and pop keeps occupancy unchanged.
    always_comb begin
        head_data_d  = head_data_q;
        head_last_d  = head_last_q;
        head_vld_d   = head_vld_q;
        spare_data_d = spare_data_q;
        spare_last_d = spare_last_q;
        spare_vld_d  = spare_vld_q;

        if (pop_c) begin
            if (spare_vld_q) begin
                head_data_d = spare_data_q;
                head_last_d = spare_last_q;
                head_vld_d  = 1'b1;
                spare_vld_d = rd_pend_q;
                if (rd_pend_q) begin
                    spare_data_d = fifo_dout;
                    spare_last_d = rd_last_pend_q;
                end
            end else begin
                head_vld_d = rd_pend_q;
                if (rd_pend_q) begin
                    head_data_d = fifo_dout;
                    head_last_d = rd_last_pend_q;
                end
            end
        end else if (rd_pend_q) begin
            if (!head_vld_q) begin
                head_data_d = fifo_dout;
                head_last_d = rd_last_pend_q;
                head_vld_d  = 1'b1;
            end else begin
                spare_data_d = fifo_dout;
                spare_last_d = rd_last_pend_q;
                spare_vld_d  = 1'b1;
            end
        end
    end

    // Single register bank; reset aborts any frame and drops in-flight data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            words_q        <= '0;
            rows_q         <= '0;
            row_cnt_q      <= '0;
            issued_q       <= '0;
            done_q         <= 1'b0;
            next_reg_q     <= 1'b0;
            rd_pend_q      <= 1'b0;
            rd_last_pend_q <= 1'b0;
            head_data_q    <= '0;
            head_last_q    <= 1'b0;
            head_vld_q     <= 1'b0;
            spare_data_q   <= '0;
            spare_last_q   <= 1'b0;
            spare_vld_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            words_q        <= words_d;
            rows_q         <= rows_d;
            row_cnt_q      <= row_cnt_d;
            issued_q       <= issued_d;
            done_q         <= done_d;
            next_reg_q     <= next_reg_d;
            rd_pend_q      <= rd_pend_d;
            rd_last_pend_q <= rd_last_pend_d;
            head_data_q    <= head_data_d;
            head_last_q    <= head_last_d;
            head_vld_q     <= head_vld_d;
            spare_data_q   <= spare_data_d;
            spare_last_q   <= spare_last_d;
            spare_vld_q    <= spare_vld_d;
        end
    end

    assign M_count   = words_q;
    assign rd_en     = rd_en_c;
    assign Next_Reg  = next_reg_q;
    assign done      = done_q;
    assign out_data  = head_data_q;
    assign out_valid = head_vld_q;
    assign out_last  = head_last_q;

endmodule

// File: doc/fifo_row_reader.md
FIFO_ROW_READER -- requirements
Module: fifo_row_reader

Interface
REQ-001 SHALL have parameter WIDTH_OUT, default 1152, width of a converted FIFO word.
REQ-002 SHALL have parameter ADDR_BITS, default 10; count ports are ADDR_BITS+1 bits wide.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  in  1  one-cycle pulse that launches a frame; ignored unless in IDLE.
REQ-006 SHALL have port row_words  in  ADDR_BITS+1  FIFO words per row, sampled on start.
REQ-007 SHALL have port row_num  in  ADDR_BITS+1  rows per frame, sampled on start.
REQ-008 SHALL have port M_count  out  ADDR_BITS+1  row threshold driven to the upstream FIFO; equals the latched row_words.
REQ-009 SHALL have port M_Ready  in  1  upstream FIFO holds at least M_count words.
REQ-010 SHALL have port empty  in  1  upstream FIFO empty flag.
REQ-011 SHALL have port fifo_dout  in  WIDTH_OUT  upstream FIFO data; valid one cycle after rd_en.
REQ-012 SHALL have port rd_en  out  1  upstream FIFO read strobe.
REQ-013 SHALL have port Next_Reg  out  1  one-cycle pulse that flushes the upstream FIFO at frame end.
REQ-014 SHALL have port out_data  out  WIDTH_OUT  word to the downstream compute stage.
REQ-015 SHALL have port out_valid  out  1  out_data is valid.
REQ-016 SHALL have port out_ready  in  1  downstream accepts; transfer when out_valid and out_ready are both high.
REQ-017 SHALL have port out_last  out  1  high with the final word of each row.
REQ-018 SHALL have port done  out  1  one-cycle pulse after the last word of the frame is transferred.

Function
REQ-019 SHALL implement the states IDLE, WAIT_ROW, READ, DRAIN, FLUSH.
REQ-020 IDLE->WAIT_ROW on start, latching row_words and row_num and clearing the row counter; if either latched value is 0, IDLE->FLUSH instead, with no reads.
REQ-021 WAIT_ROW->READ when M_Ready=1; no rd_en is issued in WAIT_ROW.
REQ-022 READ SHALL assert rd_en when empty=0, words_issued<row_words, and (skid occupancy + reads in flight)<2.
REQ-023 READ->DRAIN in the cycle the row_words-th rd_en is issued.
REQ-024 DRAIN->WAIT_ROW when all words of the row have been transferred and rows remain; DRAIN->FLUSH when the last row has been transferred.
REQ-025 FLUSH SHALL pulse Next_Reg for one cycle, pulse done for one cycle (same cycle), then return to IDLE.
REQ-026 Output buffer: a 2-entry skid FIFO SHALL capture fifo_dout one cycle after each rd_en; out_data and out_valid SHALL be driven from registers.
REQ-027 No word SHALL be lost or duplicated under arbitrary out_ready; the sustained rate SHALL be 1 word/cycle when out_ready=1 and empty=0.
REQ-028 out_last SHALL be 1 exactly on the row_words-th word of each row and SHALL travel with its data entry.
REQ-029 The row counter SHALL increment on each transfer that carries out_last; the frame ends when it reaches row_num.
REQ-030 Simultaneous push and pop in the skid buffer SHALL keep occupancy unchanged.
REQ-031 empty=1 in READ SHALL stall rd_en only; state and counters SHALL hold.
REQ-032 start asserted outside IDLE SHALL be ignored.
REQ-033 row_words=1 SHALL work: READ issues one rd_en then enters DRAIN.
REQ-034 M_count SHALL hold its latched value until the next accepted start.

Reset
REQ-035 While rst_n=0 at a clock edge: state SHALL be IDLE, all counters 0, skid buffer emptied, rd_en=0, Next_Reg=0, out_valid=0, out_last=0, done=0, M_count=0, out_data=0.
REQ-036 Reset asserted mid-frame SHALL abort the frame on that edge; in-flight read data SHALL be discarded and no done SHALL be produced.

Verification
REQ-037 row_words=4, row_num=2, M_Ready=1, empty=0, out_ready=1 -> 8 words out back-to-back, out_last on words 4 and 8, one Next_Reg/done pulse, first out_valid 2 cycles after rd_en.
REQ-038 Same setup, out_ready toggling 1/0 each cycle -> all 8 words in order, no duplicates, rd_en never leaves more than 2 words outstanding.
REQ-039 M_Ready held low 20 cycles after start -> zero rd_en pulses until M_Ready rises, then normal row.
REQ-040 row_words=3, empty=1 for 5 cycles mid-row -> rd_en low for those cycles, row completes with 3 words and out_last on the third.
REQ-041 start with row_num=0 -> no rd_en, Next_Reg and done each pulse once, return to IDLE.
REQ-042 rst_n low during READ with 2 words buffered -> next cycle out_valid=0, rd_en=0, state IDLE, no done; new start runs cleanly.
